tty_writer: RTL and testbench
=============================

TTY_WRITER -- requirements
Module: tty_writer

Interface
REQ-001 SHALL have parameter COLS, default 90, visible text columns per row.
REQ-002 SHALL have parameter ROWS, default 56, visible text rows.
REQ-003 SHALL have port pixel_clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port char_in, input, 8, byte to display or control code.
REQ-006 SHALL have port fcolor, input, 3, foreground RGB, sampled with char_in.
REQ-007 SHALL have port bcolor, input, 3, background RGB, sampled with char_in.
REQ-008 SHALL have port char_valid, input, 1, char_in/fcolor/bcolor valid.
REQ-009 SHALL have port char_ready, output, 1, byte accepted when char_valid and char_ready are both high on a clock edge.
REQ-010 SHALL have port wrdata, output, 16, screen cell {1'b0, bcolor, 1'b0, fcolor, char}.
REQ-011 SHALL have port wradr, output, 13, cell address {row[5:0], col[6:0]}, row stride 128.
REQ-012 SHALL have port wren, output, 1, one-cycle screen-memory write strobe.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE and CLEAR; char_ready SHALL be registered and high only in IDLE.
REQ-014 SHALL hold cursor registers cur_row (0..ROWS-1) and cur_col (0..COLS-1).
REQ-015 For a printable byte (0x20-0xFF) accepted in IDLE, SHALL assert wren for exactly one cycle in the next cycle at {cur_row, cur_col} with that cell, then increment cur_col; char_ready SHALL be low for that one cycle.
REQ-016 For 0x0D (CR), SHALL set cur_col=0 with no write.
REQ-017 For 0x08 (BS), SHALL decrement cur_col when it is nonzero and leave it unchanged at 0, with no write.
REQ-018 For 0x0A (LF), SHALL set cur_row=(cur_row+1) mod ROWS, leave cur_col unchanged, and enter CLEAR for that row.
REQ-019 For 0x0C (FF), SHALL enter CLEAR for all rows and then set the cursor to (0,0).
REQ-020 In CLEAR, SHALL write blank cells 0x0020 with the bcolor sampled with the triggering byte, one per cycle at consecutive addresses, covering all 128 columns of each cleared row: 128 wren cycles for LF and ROWS*128 for FF (7168 at default).
REQ-021 SHALL return to IDLE on the cycle after the last clear write, with char_ready high one cycle later.
REQ-022 SHALL ignore all other control codes (0x00-0x1F), with no write and no cursor change.
REQ-023 SHALL hold wradr and wrdata at their last values while wren is low.
REQ-024 SHALL ignore char_valid while char_ready is low; bytes presented then are not consumed.

Reset
REQ-025 While reset is high, SHALL force state=IDLE, cur_row=0, cur_col=0, wren=0, wradr=0, wrdata=0 and char_ready=0.
REQ-026 SHALL drive char_ready high on the first clock edge after reset deasserts.
REQ-027 SHALL abort any CLEAR or WRITE in progress immediately on reset, with no further wren.

Configuration
REQ-028 SHALL provide the macro TTY_AUTOWRAP_EN.
REQ-029 With TTY_AUTOWRAP_EN defined, a printable byte written at cur_col=COLS-1 SHALL set cur_col=0 and perform the LF action (row advance plus 128-cycle row clear).
REQ-030 Without TTY_AUTOWRAP_EN, cur_col SHALL saturate at COLS-1, and subsequent printable bytes SHALL overwrite that cell.

Structure
REQ-031 SHALL place state encoding, control-code constants (CR, LF, BS, FF), BLANK_CHAR=0x20 and ROW_STRIDE=128 in the shared package tty_pkg.
REQ-032 SHALL contain no sub-modules; the FSM, cursor and clear counter are one module whose outputs drive the screen write port of the text display.

Verification
REQ-033 Bench SHALL cover: reset, then 'A' (0x41) with fcolor=7 and bcolor=1 -> one wren at wradr=0 with wrdata=0x1741, then cur_col=1.
REQ-034 Bench SHALL cover: cursor at (55,3), send LF -> 128 wren cycles at wradr 0x0000-0x007F, each wrdata=0x0020|bcolor<<12, then cursor (0,3).
REQ-035 Bench SHALL cover: FF -> exactly 7168 consecutive wren cycles at wradr 0-7167, char_ready low throughout, then cursor (0,0).
REQ-036 Bench SHALL cover: cursor at (2,89) with autowrap enabled, send 'Z' -> write at wradr 0x0159, then a clear of row 3, then cursor (3,0); autowrap disabled -> cursor stays (2,89).
REQ-037 Bench SHALL cover: BS at col 0 and CR at col 40 -> no wren, cursor col 0 in both cases.
REQ-038 Bench SHALL cover: reset asserted mid-FF clear -> wren low immediately, and after release char_ready=1 with cursor (0,0).

Source files
------------

// File: rtl/tty_pkg.sv
// ============================================================================
// Module  : tty_pkg
// Brief   : Shared FSM encoding, control codes and cell helper for tty_writer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tty_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] CR = 8'h0D;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int         ROW_STRIDE = 128;

  // Screen cell layout: {pad, background, pad, foreground, character}.
  function automatic logic [15:0] make_cell(input logic [2:0] bg,
                                            input logic [2:0] fg,
                                            input logic [7:0] ch);
    return {1'b0, bg, 1'b0, fg, ch};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tty_writer.sv
// ============================================================================
// Module  : tty_writer
// Brief   : Byte-stream terminal writer driving a text-display screen memory.
//           Optional build macro TTY_AUTOWRAP_EN wraps to a new line at the
//           last column instead of saturating there.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tty_writer
  import tty_pkg::*;
#(
  parameter int COLS = 90,
  parameter int ROWS = 56
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic [2:0]  fcolor,
  input  logic [2:0]  bcolor,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [15:0] wrdata,
  output logic [12:0] wradr,
  output logic        wren
);

  localparam logic [6:0]  c_last_col = 7'(COLS - 1);
  localparam logic [5:0]  c_last_row = 6'(ROWS - 1);
  localparam logic [12:0] c_full_end = 13'(ROWS * ROW_STRIDE - 1);

  state_t      r_state;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;
  logic [12:0] r_clr_adr;
  logic [12:0] r_clr_end;
  logic [2:0]  r_clr_bcolor;
  logic        r_wrap;

  logic [5:0]  w_next_row;
  logic        w_printable;

  assign w_next_row  = (cur_row == c_last_row) ? 6'd0 : cur_row + 6'd1;
  assign w_printable = |char_in[7:5];

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      cur_row      <= '0;
      cur_col      <= '0;
      r_clr_adr    <= '0;
      r_clr_end    <= '0;
      r_clr_bcolor <= '0;
      r_wrap       <= 1'b0;
      char_ready   <= 1'b0;
      wren         <= 1'b0;
      wradr        <= '0;
      wrdata       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          wren <= 1'b0;
          // Ready re-arms one cycle after entering IDLE; bytes are only
          // consumed once it is visible to the producer.
          if (!char_ready) begin
            char_ready <= 1'b1;
          end else if (char_valid) begin
            r_clr_bcolor <= bcolor;
            if (w_printable) begin
              wren       <= 1'b1;
              wradr      <= {cur_row, cur_col};
              wrdata     <= make_cell(bcolor, fcolor, char_in);
              char_ready <= 1'b0;
              r_state    <= WRITE;
              if (cur_col == c_last_col) begin
`ifdef TTY_AUTOWRAP_EN
                cur_col <= '0;
                r_wrap  <= 1'b1;
`endif
              end else begin
                cur_col <= cur_col + 7'd1;
              end
            end else begin
              case (char_in)
                CR: cur_col <= '0;
                BS: if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
                LF: begin
                  cur_row    <= w_next_row;
                  r_clr_adr  <= {w_next_row, 7'd0};
                  r_clr_end  <= {w_next_row, 7'h7F};
                  char_ready <= 1'b0;
                  r_state    <= CLEAR;
                end
                FF: begin
                  cur_row    <= '0;
                  cur_col    <= '0;
                  r_clr_adr  <= '0;
                  r_clr_end  <= c_full_end;
                  char_ready <= 1'b0;
                  r_state    <= CLEAR;
                end
                default: ;
              endcase
            end
          end
        end

        WRITE: begin
          wren <= 1'b0;
          if (r_wrap) begin
            r_wrap    <= 1'b0;
            cur_row   <= w_next_row;
            r_clr_adr <= {w_next_row, 7'd0};
            r_clr_end <= {w_next_row, 7'h7F};
            r_state   <= CLEAR;
          end else begin
            char_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end

        CLEAR: begin
          wren      <= 1'b1;
          wradr     <= r_clr_adr;
          wrdata    <= make_cell(r_clr_bcolor, 3'd0, BLANK_CHAR);
          r_clr_adr <= r_clr_adr + 13'd1;
          if (r_clr_adr == r_clr_end) r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tty_writer.sv
// ============================================================================
// Module  : tb_tty_writer
// Brief   : Self-checking bench for tty_writer against a write-list model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tty_writer;
  import tty_pkg::*;

  localparam int COLS = 90;
  localparam int ROWS = 56;

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic [7:0]  char_in;
  logic [2:0]  fcolor;
  logic [2:0]  bcolor;
  logic        char_valid;
  logic        char_ready;
  logic [15:0] wrdata;
  logic [12:0] wradr;
  logic        wren;

  tty_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .char_in     (char_in),
    .fcolor      (fcolor),
    .bcolor      (bcolor),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .wrdata      (wrdata),
    .wradr       (wradr),
    .wren        (wren)
  );

  always #5 pixel_clock = ~pixel_clock;

  int checks = 0;
  int errors = 0;
  int mrow = 0;
  int mcol = 0;
  int exp_adr[$];
  int exp_dat[$];
  int got_adr[$];
  int got_dat[$];
  int got_idx[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic blank_row(input int r, input int b);
    for (int k = 0; k < 128; k++) begin
      exp_adr.push_back(r * 128 + k);
      exp_dat.push_back((b << 12) | 32);
    end
  endtask

  // Expected screen writes and cursor movement for one accepted byte.
  task automatic model_byte(input int c, input int f, input int b);
    exp_adr.delete();
    exp_dat.delete();
    if (c >= 32) begin
      exp_adr.push_back(mrow * 128 + mcol);
      exp_dat.push_back((b << 12) | (f << 8) | c);
      if (mcol == COLS - 1) begin
`ifdef TTY_AUTOWRAP_EN
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        blank_row(mrow, b);
`endif
      end else begin
        mcol++;
      end
    end else if (c == 8'h0A) begin
      mrow = (mrow + 1) % ROWS;
      blank_row(mrow, b);
    end else if (c == 8'h0C) begin
      for (int r = 0; r < ROWS; r++) blank_row(r, b);
      mrow = 0;
      mcol = 0;
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h08) begin
      if (mcol > 0) mcol--;
    end
  endtask

  task automatic send(input string tag, input logic [7:0] c,
                      input logic [2:0] f, input logic [2:0] b);
    int n;
    int mism;
    n = 0;
    while (!char_ready) begin
      @(negedge pixel_clock);
      if (++n > 20000) begin
        chk({tag, " ready_timeout"}, 0, 1);
        return;
      end
    end
    char_in    = c;
    fcolor     = f;
    bcolor     = b;
    char_valid = 1'b1;
    @(posedge pixel_clock);
    #1 char_valid = 1'b0;
    model_byte(int'(c), int'(f), int'(b));

    got_adr.delete();
    got_dat.delete();
    got_idx.delete();
    n = 0;
    forever begin
      @(negedge pixel_clock);
      if (wren) begin
        got_adr.push_back(int'(wradr));
        got_dat.push_back(int'(wrdata));
        got_idx.push_back(n);
      end
      if (char_ready) break;
      if (++n > 20000) begin
        chk({tag, " done_timeout"}, 0, 1);
        break;
      end
    end

    chk({tag, " wren_count"}, got_adr.size(), exp_adr.size());
    mism = 0;
    for (int i = 0; i < got_adr.size() && i < exp_adr.size(); i++)
      if (got_adr[i] != exp_adr[i] || got_dat[i] != exp_dat[i]) begin
        if (mism == 0)
          $display("first diff at %0d: adr 0x%0h/0x%0h data 0x%0h/0x%0h", i,
                   got_adr[i], exp_adr[i], got_dat[i], exp_dat[i]);
        mism++;
      end
    chk({tag, " cell_diffs"}, mism, 0);
    if (got_idx.size() > 1)
      chk({tag, " contiguous"}, got_idx[got_idx.size()-1] - got_idx[0] + 1,
          got_idx.size());
    chk({tag, " cursor"}, int'(dut.cur_row) * 128 + int'(dut.cur_col),
        mrow * 128 + mcol);
  endtask

  initial begin
    logic [7:0] c;
    int         k;

    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = '0;
    fcolor     = '0;
    bcolor     = '0;
    repeat (3) @(posedge pixel_clock);
    #1;
    chk("rst wren", int'(wren), 0);
    chk("rst ready", int'(char_ready), 0);
    chk("rst wradr", int'(wradr), 0);
    chk("rst wrdata", int'(wrdata), 0);
    @(negedge pixel_clock) reset = 1'b0;
    @(negedge pixel_clock);
    chk("ready after reset", int'(char_ready), 1);

    send("A", 8'h41, 3'd7, 3'd1);
    chk("A wradr", got_adr.size() > 0 ? got_adr[0] : -1, 0);
    chk("A wrdata", got_dat.size() > 0 ? got_dat[0] : -1, 16'h1741);

    repeat (60) begin
      k = $urandom_range(0, 9);
      if (k <= 5)      c = 8'($urandom_range(32, 255));
      else if (k == 6) c = CR;
      else if (k == 7) c = BS;
      else if (k == 8) c = 8'($urandom_range(0, 31));
      else             c = LF;
      if (c == FF) c = 8'h00;
      send("rand", c, 3'($urandom), 3'($urandom));
    end

    send("FF1", FF, 3'd2, 3'd6);
    repeat (55) send("LFstep", LF, 3'd0, 3'($urandom));
    repeat (3) send("pr", 8'($urandom_range(32, 255)), 3'd3, 3'd4);
    send("LF wrap", LF, 3'd1, 3'd5);
    chk("LF wrap first adr", got_adr.size() > 0 ? got_adr[0] : -1, 0);

    send("CR", CR, 3'd0, 3'd0);
    send("BS col0", BS, 3'd0, 3'd0);
    repeat (40) send("pr40", 8'($urandom_range(32, 255)), 3'($urandom), 3'($urandom));
    send("BS", BS, 3'd0, 3'd0);
    send("pr", 8'h58, 3'd2, 3'd0);
    send("CR col40", CR, 3'd0, 3'd0);

    send("FF2", FF, 3'd0, 3'd0);
    send("LF1", LF, 3'd0, 3'd0);
    send("LF2", LF, 3'd0, 3'd0);
    repeat (89) send("pr89", 8'($urandom_range(32, 255)), 3'd7, 3'd0);
    send("Z edge", 8'h5A, 3'd6, 3'd2);
    chk("Z adr", got_adr.size() > 0 ? got_adr[0] : -1, 13'h159);
    send("Z again", 8'h5A, 3'd5, 3'd3);

    // Reset landing in the middle of a full-screen clear.
    while (!char_ready) @(negedge pixel_clock);
    char_in    = FF;
    bcolor     = 3'd7;
    char_valid = 1'b1;
    @(posedge pixel_clock);
    #1 char_valid = 1'b0;
    repeat (100) @(negedge pixel_clock);
    chk("midFF clearing", int'(wren), 1);
    reset = 1'b1;
    #1;
    chk("midFF wren", int'(wren), 0);
    chk("midFF ready", int'(char_ready), 0);
    repeat (2) @(negedge pixel_clock);
    chk("midFF wren held", int'(wren), 0);
    reset = 1'b0;
    mrow  = 0;
    mcol  = 0;
    @(negedge pixel_clock);
    chk("post ready", int'(char_ready), 1);
    chk("post cursor", int'(dut.cur_row) * 128 + int'(dut.cur_col), 0);
    send("B", 8'h42, 3'd4, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
